tcp_rwnd_clamp: RTL and testbench

- Inline user-datapath stage. Uses the 64-bit data / 8-bit ctrl module-header packet bus.
- Rewrites the TCP receive-window field of IPv4/TCP packets. Clamps it to a configured maximum, or forces it to a configured value.
- Patches the TCP checksum incrementally (RFC 1624) in the same word.
- Enabled per source port through a port mask. All other traffic passes unmodified.

---
 rtl/tcp_rwnd_clamp.sv | 138 +++++++++++++
 tb/tb_tcp_rwnd_clamp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_rwnd_clamp.sv
// tcp_rwnd_clamp: clamps or forces the TCP receive window of IPv4/TCP packets and patches the checksum in the same word
module tcp_rwnd_clamp #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_PORTS = 8,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = 8'hFF,
  parameter int SRC_PORT_LSB = 16,
  parameter int FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  cfg_enable,
  input  logic                  cfg_mode,
  input  logic [15:0]           cfg_win_max,
  input  logic [NUM_PORTS-1:0]  cfg_port_mask,
  output logic [31:0]           pkt_tcp_cnt,
  output logic [31:0]           win_mod_cnt
);
  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW = FIFO_DEPTH_BITS + 1;
  typedef enum logic [1:0] {MOD_HDR, HDR, WIN, PASS} state_t;
  logic [DATA_WIDTH-1:0] r_mem_d [DEPTH];
  logic [CTRL_WIDTH-1:0] r_mem_c [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  state_t r_state, w_nxt;
  logic [2:0] r_wc;
  logic r_elig, r_mode;
  logic [15:0] r_win_max;
  logic [31:0] r_pkt, r_mod;
  logic w_push, w_pop, w_is_data, w_port_ok, w_chk_ok, w_changed;
  logic [DATA_WIDTH-1:0] w_d, w_out_d;
  logic [CTRL_WIDTH-1:0] w_c;
  logic [15:0] w_src, w_win, w_csum, w_new_win, w_ncs, w_nwin, w_f2, w_new_csum;
  logic [17:0] w_sum;
  logic [16:0] w_f1;
  assign w_push = in_wr & (r_cnt != CW'(DEPTH));
  assign w_pop = (r_cnt != '0) & out_rdy;
  assign in_rdy = r_cnt < CW'(DEPTH - 1);
  assign w_d = r_mem_d[r_rp];
  assign w_c = r_mem_c[r_rp];
  assign w_is_data = w_c == '0;
  assign pkt_tcp_cnt = r_pkt;
  assign win_mod_cnt = r_mod;
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_d[r_wp] <= in_data;
      r_mem_c[r_wp] <= in_ctrl;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + FIFO_DEPTH_BITS'(w_push);
      r_rp <= r_rp + FIFO_DEPTH_BITS'(w_pop);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  assign w_src = w_d[SRC_PORT_LSB+:16];
  assign w_port_ok = (w_src < 16'(NUM_PORTS)) && |(cfg_port_mask & (NUM_PORTS'(1) << w_src));
  assign w_chk_ok = (r_wc == 3'd1) ? (w_d[31:16] == 16'h0800 && w_d[15:8] == 8'h45) :
                    (r_wc == 3'd2) ? (w_d[7:0] == 8'h06 && w_d[28:16] == 13'd0) : 1'b1;
  assign w_win = w_d[63:48];
  assign w_csum = w_d[47:32];
  assign w_new_win = r_mode ? r_win_max : (w_win > r_win_max) ? r_win_max : w_win;
  assign w_changed = w_new_win != w_win;
  assign w_ncs = ~w_csum;
  assign w_nwin = ~w_win;
  // one's-complement sum of ~C + ~W + W', end-around carry folded twice
  assign w_sum = {2'b0, w_ncs} + {2'b0, w_nwin} + {2'b0, w_new_win};
  assign w_f1 = {1'b0, w_sum[15:0]} + {15'b0, w_sum[17:16]};
  assign w_f2 = w_f1[15:0] + {15'b0, w_f1[16]};
  assign w_new_csum = ~w_f2;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= MOD_HDR;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = r_state;
    if (w_pop) begin
      case (r_state)
        MOD_HDR: w_nxt = w_is_data ? HDR : MOD_HDR;
        HDR:     w_nxt = !w_is_data ? MOD_HDR : (r_wc == 3'd5) ? (r_elig ? WIN : PASS) : HDR;
        WIN:     w_nxt = w_is_data ? PASS : MOD_HDR;
        default: w_nxt = w_is_data ? PASS : MOD_HDR;
      endcase
    end
  end
  always_comb begin
    w_out_d = (r_state == WIN && w_changed) ? {w_new_win, w_new_csum, w_d[31:0]} : w_d;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wc <= 3'd0;
      r_elig <= 1'b0;
      r_mode <= 1'b0;
      r_win_max <= 16'd0;
      r_pkt <= 32'd0;
      r_mod <= 32'd0;
    end else if (w_pop) begin
      if (r_state == MOD_HDR && w_c == IOQ_CTRL) begin
        r_elig <= cfg_enable & w_port_ok;
        r_mode <= cfg_mode;
        r_win_max <= cfg_win_max;
      end else if (r_state != MOD_HDR && !w_is_data) r_elig <= 1'b0;
      else if (r_state == HDR && !w_chk_ok) r_elig <= 1'b0;
      r_wc <= (r_state == MOD_HDR) ? 3'd1 : (r_wc == 3'd7) ? r_wc : r_wc + 3'd1;
      if (r_state == WIN) begin
        r_pkt <= r_pkt + 32'd1;
        r_mod <= r_mod + {31'd0, w_changed};
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_wr <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= w_pop;
      if (w_pop) begin
        out_data <= w_out_d;
        out_ctrl <= w_c;
      end
    end
  end
endmodule

// File: tb/tb_tcp_rwnd_clamp.sv
// tb_tcp_rwnd_clamp: scoreboard bench with a packet-level reference model for tcp_rwnd_clamp
module tb_tcp_rwnd_clamp;
  logic clk = 1'b0;
  logic reset_n;
  logic [63:0] in_data, out_data;
  logic [7:0] in_ctrl, out_ctrl;
  logic in_wr, in_rdy, out_wr, out_rdy;
  logic cfg_enable, cfg_mode;
  logic [15:0] cfg_win_max;
  logic [7:0] cfg_port_mask;
  logic [31:0] pkt_tcp_cnt, win_mod_cnt;
  typedef struct {logic [7:0] c; logic [63:0] d; int cyc; bit lat;} exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [63:0] pk_d[$], ex_d[$];
  logic [7:0] pk_c[$], ex_c[$];
  int checks = 0, errs = 0, cyc = 0, m_pkt = 0, m_mod = 0;
  bit rand_rdy = 0;
  tcp_rwnd_clamp dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr),
    .in_rdy(in_rdy), .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .cfg_enable(cfg_enable), .cfg_mode(cfg_mode), .cfg_win_max(cfg_win_max),
    .cfg_port_mask(cfg_port_mask), .pkt_tcp_cnt(pkt_tcp_cnt), .win_mod_cnt(win_mod_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, r);
    end
  endtask
  always @(negedge clk) begin
    if (reset_n && out_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_word: got %h/%h expected no output", out_ctrl, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word_ctrl", 64'(out_ctrl), 64'(e.c));
        chk("word_data", out_data, e.d);
        if (e.lat) chk("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end
  initial begin
    out_rdy = 1'b1;
    forever begin
      @(negedge clk);
      out_rdy = rand_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  function automatic logic [15:0] oc_fix(input logic [15:0] c, input logic [15:0] w, input logic [15:0] wn);
    int s;
    s = (~c & 16'hFFFF) + (~w & 16'hFFFF) + wn;
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    return 16'(~s);
  endfunction
  task automatic build(input int src, input logic [15:0] eth, input logic [7:0] vi, input logic [7:0] pr,
                       input logic [15:0] fr, input logic [15:0] w, input logic [15:0] cs, input int n);
    logic [63:0] d;
    logic [15:0] wn;
    pk_d.delete();
    pk_c.delete();
    d = {$urandom(), $urandom()};
    d[31:16] = 16'(src);
    pk_d.push_back(d);
    pk_c.push_back(8'hFF);
    for (int k = 1; k <= n; k++) begin
      d = {$urandom(), $urandom()};
      if (k == 2) begin d[31:16] = eth; d[15:8] = vi; end
      if (k == 3) begin d[31:16] = fr; d[7:0] = pr; end
      if (k == 7) begin d[63:48] = w; d[47:32] = cs; end
      pk_d.push_back(d);
      pk_c.push_back(k == n ? 8'($urandom_range(1, 255)) : 8'h00);
    end
    ex_d = pk_d;
    ex_c = pk_c;
    if (n >= 7 && cfg_enable && src < 8 && cfg_port_mask[src] && eth == 16'h0800 && vi == 8'h45 &&
        pr == 8'h06 && (fr & 16'h1FFF) == 0) begin
      wn = cfg_mode ? cfg_win_max : (w > cfg_win_max ? cfg_win_max : w);
      m_pkt++;
      if (wn != w) begin
        m_mod++;
        d = ex_d[7];
        d[63:48] = wn;
        d[47:32] = oc_fix(cs, w, wn);
        ex_d[7] = d;
      end
    end
  endtask
  task automatic drive_word(input logic [7:0] c, input logic [63:0] d, input logic [7:0] ec,
                            input logic [63:0] ed, input bit lat);
    exp_t x;
    int g = 0;
    @(negedge clk);
    while (!in_rdy && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!in_rdy) begin
      $display("FAIL in_rdy_timeout: got 0 expected 1");
      $fatal(1);
    end
    in_wr = 1'b1;
    in_ctrl = c;
    in_data = d;
    x.c = ec; x.d = ed; x.cyc = cyc; x.lat = lat;
    exp_q.push_back(x);
    @(posedge clk);
    #1 in_wr = 1'b0;
  endtask
  task automatic send(input int from, input int to, input bit lat);
    for (int i = from; i < to; i++) drive_word(pk_c[i], pk_d[i], ex_c[i], ex_d[i], lat && i == from);
  endtask
  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending words expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic chk_cnt();
    chk("pkt_tcp_cnt", 64'(pkt_tcp_cnt), 64'(m_pkt));
    chk("win_mod_cnt", 64'(win_mod_cnt), 64'(m_mod));
  endtask
  task automatic set_cfg(input logic en, input logic md, input logic [15:0] mx, input logic [7:0] mk);
    cfg_enable = en; cfg_mode = md; cfg_win_max = mx; cfg_port_mask = mk;
  endtask
  initial begin
    reset_n = 1'b0; in_wr = 1'b0; in_data = '0; in_ctrl = '0;
    set_cfg(1'b0, 1'b0, 16'h0, 8'h0);
    repeat (3) @(negedge clk);
    chk("rst_out_wr", 64'(out_wr), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk_cnt();
    reset_n = 1'b1;
    set_cfg(1'b1, 1'b0, 16'h2000, 8'h01);
    build(0, 16'h0800, 8'h45, 8'h06, 16'h4000, 16'hFFFF, 16'h1234, 8);
    chk("model_clamp_csum", 64'(ex_d[7][47:32]), 64'h0000_0000_0000_F233);
    send(0, pk_d.size(), 1'b1);
    drain();
    chk_cnt();
    build(0, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'h1000, 16'h5A5A, 9);
    send(0, pk_d.size(), 1'b1);
    drain();
    chk_cnt();
    set_cfg(1'b1, 1'b1, 16'h4000, 8'h01);
    build(0, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'h1000, 16'hBEEF, 7);
    send(0, pk_d.size(), 1'b0);
    drain();
    chk_cnt();
    build(0, 16'h0800, 8'h45, 8'h11, 16'h0000, 16'h1000, 16'h1111, 8);
    send(0, pk_d.size(), 1'b0);
    build(0, 16'h0806, 8'h45, 8'h06, 16'h0000, 16'h1000, 16'h2222, 8);
    send(0, pk_d.size(), 1'b0);
    build(0, 16'h0800, 8'h46, 8'h06, 16'h0000, 16'h1000, 16'h3333, 8);
    send(0, pk_d.size(), 1'b0);
    build(3, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'h1000, 16'h4444, 8);
    send(0, pk_d.size(), 1'b0);
    build(0, 16'h0800, 8'h45, 8'h06, 16'h0010, 16'h1000, 16'h5555, 8);
    send(0, pk_d.size(), 1'b0);
    build(0, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'h1000, 16'h6666, 6);
    send(0, pk_d.size(), 1'b0);
    drain();
    chk_cnt();
    set_cfg(1'b1, 1'b0, 16'h3000, 8'h03);
    build(1, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'h8000, 16'h0F0F, 9);
    send(0, 2, 1'b0);
    drain();
    set_cfg(1'b1, 1'b1, 16'h0100, 8'h00);
    send(2, pk_d.size(), 1'b0);
    drain();
    chk_cnt();
    rand_rdy = 1;
    for (int ph = 0; ph < 4; ph++) begin
      set_cfg(1'($urandom % 4 != 0), 1'($urandom % 2), 16'($urandom), 8'($urandom));
      for (int p = 0; p < 25; p++) begin
        build($urandom_range(0, 9), ($urandom % 10 == 0) ? 16'h0806 : 16'h0800,
              ($urandom % 10 == 0) ? 8'h46 : 8'h45, ($urandom % 5 == 0) ? 8'h11 : 8'h06,
              ($urandom % 7 == 0) ? 16'($urandom) : 16'h4000, 16'($urandom), 16'($urandom),
              ($urandom % 7 == 0) ? 2 : $urandom_range(6, 10));
        send(0, pk_d.size(), 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      drain();
      chk_cnt();
    end
    rand_rdy = 0;
    set_cfg(1'b1, 1'b0, 16'h2000, 8'h01);
    build(0, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'hFFFF, 16'h1234, 8);
    send(0, 5, 1'b0);
    #1 reset_n = 1'b0;
    exp_q.delete();
    m_pkt = 0;
    m_mod = 0;
    #1;
    chk("midrst_out_wr", 64'(out_wr), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk_cnt();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    build(0, 16'h0800, 8'h45, 8'h06, 16'h0000, 16'hFFFF, 16'h1234, 8);
    send(0, pk_d.size(), 1'b1);
    drain();
    chk_cnt();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
